// File: rtl/usb_tx_pkg.sv
// Shared types and line-symbol constants for the USB full-speed transmit serializer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // {d_plus, d_minus}
  localparam logic [1:0] J_SYM   = 2'b10;
  localparam logic [1:0] K_SYM   = 2'b01;
  localparam logic [1:0] SE0_SYM = 2'b00;

  // NRZI level: 1 = J, 0 = K. A 0 bit toggles, a 1 bit holds.
  function automatic logic nrzi_next(input logic lvl, input logic b);
    return b ? lvl : ~lvl;
  endfunction

  function automatic logic [1:0] line_sym(input logic lvl);
    return lvl ? J_SYM : K_SYM;
  endfunction

endpackage

// File: rtl/usb_tx_serializer_if.sv
// Byte handshake between the packet source and the USB transmit serializer.
interface usb_tx_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/flex_counter.sv
// Free-running modulo counter; rollover_flag marks the last count before wrapping to 0.
module flex_counter #(
  parameter int NUM_CNT_BITS = 3
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  count_enable,
  input  logic [NUM_CNT_BITS:0] rollover_val,
  output logic                  rollover_flag
);
  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  assign rollover_flag = ({1'b0, count_q} == rollover_val - (NUM_CNT_BITS+1)'(1));

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (count_enable)
      count_d = rollover_flag ? '0 : count_q + NUM_CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/usb_tx_serializer.sv
// USB FS transmit bit engine: SYNC, LSB-first data, NRZI, EOP on D+/D-.
// Bit stuffing is built only when USB_TX_BITSTUFF_EN is defined.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int BIT_CLKS    = 8,
  parameter int STUFF_LIMIT = 6
) (
  input  logic                clk,
  input  logic                n_rst,
  usb_tx_serializer_if.slave  tx,
  output logic                tx_busy,
  output logic                bit_strobe,
  output logic                d_plus,
  output logic                d_minus
);
  localparam int          CW   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW:0] ROLL = (CW+1)'(BIT_CLKS);

  // The ones counter is 3 bits wide, which bounds STUFF_LIMIT.
  if (BIT_CLKS < 2 || STUFF_LIMIT < 1 || STUFF_LIMIT > 7) begin : g_bad_param
    $error("usb_tx_serializer: unsupported BIT_CLKS/STUFF_LIMIT");
  end

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bidx_q,  bidx_d;
  logic       nrzi_q,  nrzi_d;
  logic [1:0] line_q,  line_d;
  logic       strobe, timer_clr, fetch, stuff_now;
`ifdef USB_TX_BITSTUFF_EN
  localparam logic [2:0] LIM = 3'(STUFF_LIMIT);
  logic [2:0] ones_q, ones_d, ones_inc;
  logic       loaded_q, loaded_d;
`endif

  assign timer_clr = (state_q == IDLE);

  flex_counter #(.NUM_CNT_BITS(CW)) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (timer_clr),
    .count_enable (1'b1),
    .rollover_val (ROLL),
    .rollover_flag(strobe)
  );

  assign bit_strobe = strobe;
  assign tx_busy    = (state_q != IDLE);
  assign d_plus     = line_q[1];
  assign d_minus    = line_q[0];

  // Everything below advances only on bit boundaries; line_d is the symbol for the next period.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bidx_d      = bidx_q;
    nrzi_d      = nrzi_q;
    line_d      = line_q;
    fetch       = 1'b0;
    stuff_now   = 1'b0;
    tx.tx_ready = 1'b0;
`ifdef USB_TX_BITSTUFF_EN
    ones_d   = ones_q;
    loaded_d = loaded_q;
    ones_inc = (ones_q >= LIM) ? LIM : ones_q + 3'd1;
`endif
    case (state_q)
      IDLE: if (tx.tx_valid) begin
        state_d = SYNC;
        shift_d = SYNC_BYTE;
        bidx_d  = '0;
        nrzi_d  = nrzi_next(1'b1, SYNC_BYTE[0]);
        line_d  = line_sym(nrzi_d);
`ifdef USB_TX_BITSTUFF_EN
        ones_d  = '0;
`endif
      end
      SYNC, DATA: if (strobe) begin
        fetch   = (bidx_q == 3'd7);
        shift_d = {1'b0, shift_q[7:1]};
        bidx_d  = bidx_q + 3'd1;
`ifdef USB_TX_BITSTUFF_EN
        ones_d    = shift_q[0] ? ones_inc : '0;
        stuff_now = shift_q[0] && (ones_inc == LIM);
        if (fetch) loaded_d = tx.tx_valid;
`endif
        if (fetch) begin
          tx.tx_ready = tx.tx_valid;
          if (tx.tx_valid) shift_d = tx.tx_data;
        end
        // A stuff bit owed after bit 7 goes out before the next byte or EOP.
        if (stuff_now) begin
          state_d = STUFF;
          nrzi_d  = ~nrzi_q;
          line_d  = line_sym(nrzi_d);
        end else if (fetch && !tx.tx_valid) begin
          state_d = EOP_SE0;
          line_d  = SE0_SYM;
        end else begin
          if (fetch) state_d = DATA;
          nrzi_d = nrzi_next(nrzi_q, shift_d[0]);
          line_d = line_sym(nrzi_d);
        end
      end
`ifdef USB_TX_BITSTUFF_EN
      STUFF: if (strobe) begin
        ones_d = '0;
        if (bidx_q == 3'd0 && !loaded_q) begin
          state_d = EOP_SE0;
          line_d  = SE0_SYM;
        end else begin
          state_d = DATA;
          nrzi_d  = nrzi_next(nrzi_q, shift_q[0]);
          line_d  = line_sym(nrzi_d);
        end
      end
`endif
      EOP_SE0: if (strobe) begin
        if (bidx_q == 3'd1) begin
          state_d = EOP_J;
          bidx_d  = '0;
          nrzi_d  = 1'b1;
          line_d  = J_SYM;
        end else begin
          bidx_d  = bidx_q + 3'd1;
        end
      end
      EOP_J: if (strobe) begin
        state_d = IDLE;
        nrzi_d  = 1'b1;
        line_d  = J_SYM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bidx_q   <= '0;
      nrzi_q   <= 1'b1;
      line_q   <= J_SYM;
`ifdef USB_TX_BITSTUFF_EN
      ones_q   <= '0;
      loaded_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bidx_q   <= bidx_d;
      nrzi_q   <= nrzi_d;
      line_q   <= line_d;
`ifdef USB_TX_BITSTUFF_EN
      ones_q   <= ones_d;
      loaded_q <= loaded_d;
`endif
    end
  end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// Table-driven bench for usb_tx_serializer with a per-cycle line-symbol scoreboard.
module tb_usb_tx_serializer;
  localparam int BC = 8;
`ifdef USB_TX_BITSTUFF_EN
  localparam int SB       = 8;
  localparam bit STUFF_ON = 1'b1;
`else
  localparam int SB       = 0;
  localparam bit STUFF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic tx_busy, bit_strobe, d_plus, d_minus;

  usb_tx_serializer_if tif();

  usb_tx_serializer #(.BIT_CLKS(BC), .STUFF_LIMIT(6)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx        (tif),
    .tx_busy   (tx_busy),
    .bit_strobe(bit_strobe),
    .d_plus    (d_plus),
    .d_minus   (d_minus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    int         busy;
    int         r1;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [1:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference bit stream: SYNC + bytes LSB first, stuff after six 1s, NRZI from J, then EOP.
  task automatic push_expected(input int n, input logic [7:0] b0, input logic [7:0] b1);
    logic       lvl = 1'b1;
    int         ones = 0;
    logic [7:0] sync = 8'h80;
    logic [7:0] byt;
    logic [2:0] bi;
    logic       b;
    for (int i = 0; i < 8*(n+1); i++) begin
      byt = (i < 8) ? sync : ((i < 16) ? b0 : b1);
      bi  = 3'(i);
      b   = byt[bi];
      lvl = b ? lvl : ~lvl;
      sb.push_back(lvl ? 2'b10 : 2'b01);
      ones = b ? ones + 1 : 0;
      if (STUFF_ON && ones == 6) begin
        lvl = ~lvl;
        sb.push_back(lvl ? 2'b10 : 2'b01);
        ones = 0;
      end
    end
    sb.push_back(2'b00);
    sb.push_back(2'b00);
    sb.push_back(2'b10);
  endtask

  task automatic run_vec(input vec_t v);
    int   busy_cnt = 0;
    int   nready = 0;
    bit   upd = 1'b0;
    bit   done = 1'b0;
    push_expected(v.n, v.b0, v.b1);
    tif.tx_valid = 1'b1;
    tif.tx_data  = v.b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (upd) begin
        if (nready < v.n) tif.tx_data = v.b1;
        else              tif.tx_valid = 1'b0;
        upd = 1'b0;
      end
      if (tx_busy) begin
        busy_cnt++;
        chk({v.nm, "_strobe"}, 32'(bit_strobe), 32'(busy_cnt % BC == 0));
        if (sb.size() == 0) chk({v.nm, "_sb_underflow"}, 32'(1), 32'(0));
        else chk({v.nm, "_line"}, 32'({d_plus, d_minus}), 32'(sb[0]));
        if (bit_strobe && sb.size() != 0) void'(sb.pop_front());
      end
      if (tif.tx_ready) begin
        nready++;
        chk({v.nm, "_ready_time"}, 32'(k), 32'((nready == 1) ? 64 : v.r1));
        upd = 1'b1;
      end
      if (busy_cnt > 0 && !tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk({v.nm, "_timeout"}, 32'(0), 32'(1));
      tif.tx_valid = 1'b0;
    end
    chk({v.nm, "_busy_len"}, 32'(busy_cnt), 32'(v.busy));
    chk({v.nm, "_ready_cnt"}, 32'(nready), 32'(v.n));
    chk({v.nm, "_sb_left"}, 32'(sb.size()), 32'(0));
    chk({v.nm, "_idle_line"}, 32'({d_plus, d_minus}), 32'(2'b10));
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   bad;
    tbl[0] = '{nm:"a5",      n:1, b0:8'hA5, b1:8'h00, busy:152,      r1:0};
    tbl[1] = '{nm:"ff",      n:1, b0:8'hFF, b1:8'h00, busy:152 + SB, r1:0};
    tbl[2] = '{nm:"00_01",   n:2, b0:8'h00, b1:8'h01, busy:216,      r1:128};
    tbl[3] = '{nm:"ff_00",   n:2, b0:8'hFF, b1:8'h00, busy:216 + SB, r1:128 + SB};
    tbl[4] = '{nm:"fc_81",   n:2, b0:8'hFC, b1:8'h81, busy:216 + SB, r1:128};
    tbl[5] = '{nm:"fc_eop",  n:1, b0:8'hFC, b1:8'h00, busy:152 + SB, r1:0};

    tif.tx_valid = 1'b0;
    tif.tx_data  = 8'h00;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dplus",  32'(d_plus),       32'(1));
    chk("rst_dminus", 32'(d_minus),      32'(0));
    chk("rst_ready",  32'(tif.tx_ready), 32'(0));
    chk("rst_busy",   32'(tx_busy),      32'(0));
    chk("rst_strobe", 32'(bit_strobe),   32'(0));
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Abort in the middle of bit 4 of a data byte.
    tif.tx_valid = 1'b1;
    tif.tx_data  = 8'h00;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 64) chk("mid_ready64", 32'(tif.tx_ready), 32'(1));
      if (k == 65) tif.tx_valid = 1'b0;
      if (k == 98) chk("mid_busy", 32'(tx_busy), 32'(1));
    end
    n_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_line",   32'({d_plus, d_minus}), 32'(2'b10));
    chk("mid_rst_busy",   32'(tx_busy),           32'(0));
    chk("mid_rst_strobe", 32'(bit_strobe),        32'(0));
    n_rst = 1'b1;
    bad = 0;
    repeat (24) begin
      @(negedge clk);
      if ({d_plus, d_minus} !== 2'b10 || tx_busy !== 1'b0) bad++;
    end
    chk("mid_rst_no_eop", 32'(bad), 32'(0));

    run_vec(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
